// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Brief    : Shared types and constants for the RV32 instruction encoder:
//            immediate format enum, canonical NOP and per-format immediate
//            limits.
// Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

    // Immediate format selector; encodings 5..7 are illegal.
    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_U = 3'd3,
        FMT_J = 3'd4
    } fmt_e;

    // addi x0, x0, 0
    localparam logic [31:0] c_nop = 32'h0000_0013;

    // Representable immediate ranges (byte offsets for B/J).
    localparam int c_imm_is_min = -2048;
    localparam int c_imm_is_max = 2047;
    localparam int c_imm_b_min  = -4096;
    localparam int c_imm_b_max  = 4094;
    localparam int c_imm_j_min  = -1048576;
    localparam int c_imm_j_max  = 1048574;

    // True for the five defined formats.
    function automatic logic fmt_is_legal(input logic [2:0] fmt);
        return (fmt <= 3'd4);
    endfunction

endpackage : core_pkg
`default_nettype wire

// File: rtl/imm_range_check.sv
`default_nettype none
// ============================================================================
// Module   : imm_range_check
// Brief    : Combinational immediate checker. Flags immediates that do not
//            fit their format, misaligned branch/jump offsets and illegal
//            format codes. Range/align flags are suppressed for illegal fmt.
// Revision : 1.0 - initial release
// ============================================================================
module imm_range_check
    import core_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    output logic        range_err,
    output logic        align_err,
    output logic        fmt_err
);

    int w_simm;

    assign w_simm = $signed(imm);

    // Per-format representability and alignment checks.
    always_comb begin
        range_err = 1'b0;
        align_err = 1'b0;
        fmt_err   = !fmt_is_legal(fmt);
        case (fmt_e'(fmt))
            FMT_I, FMT_S: begin
                range_err = (w_simm < c_imm_is_min) || (w_simm > c_imm_is_max);
            end
            FMT_B: begin
                range_err = (w_simm < c_imm_b_min) || (w_simm > c_imm_b_max);
                align_err = imm[0];
            end
            FMT_U: begin
                range_err = (imm[11:0] != 12'h000);
            end
            FMT_J: begin
                range_err = (w_simm < c_imm_j_min) || (w_simm > c_imm_j_max);
                align_err = imm[0];
            end
            default: begin
                range_err = 1'b0;
                align_err = 1'b0;
            end
        endcase
    end

endmodule : imm_range_check
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Brief    : Two-stage valid/ready RV32 instruction encoder. S1 captures the
//            request together with its immediate check results; S2 holds the
//            assembled word and flags. Counts erroneous requests at the input
//            handshake with a saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder
    import core_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           fmt,
    input  logic [6:0]           opcode,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic [31:0]          imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          instr,
    output logic                 range_err,
    output logic                 align_err,
    output logic                 fmt_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    // Stage 1 request registers
    logic        r_s1_valid;
    logic [2:0]  r_s1_fmt;
    logic [6:0]  r_s1_opcode;
    logic [4:0]  r_s1_rd;
    logic [4:0]  r_s1_rs1;
    logic [4:0]  r_s1_rs2;
    logic [2:0]  r_s1_funct3;
    logic [31:0] r_s1_imm;
    logic        r_s1_range_err;
    logic        r_s1_align_err;
    logic        r_s1_fmt_err;

    // Stage 2 output registers
    logic        r_s2_valid;
    logic [31:0] r_s2_instr;
    logic        r_s2_range_err;
    logic        r_s2_align_err;
    logic        r_s2_fmt_err;

    logic [ERR_CNT_W-1:0] r_err_count;

    logic        w_s2_advance;
    logic        w_s1_advance;
    logic        w_in_fire;
    logic        w_chk_range;
    logic        w_chk_align;
    logic        w_chk_fmt;
    logic [31:0] w_word;
    logic        w_unused;

    // funct7 is reserved for a future R-type path and deliberately ignored.
    assign w_unused = ^funct7;

    // Handshake: only out_ready sits on the combinational path to in_ready.
    assign w_s2_advance = !r_s2_valid || out_ready;
    assign w_s1_advance = r_s1_valid && w_s2_advance;
    assign in_ready     = !r_s1_valid || w_s1_advance;
    assign w_in_fire    = in_valid && in_ready;

    // Checks run on the incoming request so the error counter can update at
    // the handshake; the results are captured alongside the request in S1.
    imm_range_check u_imm_range_check (
        .fmt       (fmt),
        .imm       (imm),
        .range_err (w_chk_range),
        .align_err (w_chk_align),
        .fmt_err   (w_chk_fmt)
    );

    // S1: capture the request and its check results whenever S1 can accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid     <= 1'b0;
            r_s1_fmt       <= 3'd0;
            r_s1_opcode    <= 7'd0;
            r_s1_rd        <= 5'd0;
            r_s1_rs1       <= 5'd0;
            r_s1_rs2       <= 5'd0;
            r_s1_funct3    <= 3'd0;
            r_s1_imm       <= 32'd0;
            r_s1_range_err <= 1'b0;
            r_s1_align_err <= 1'b0;
            r_s1_fmt_err   <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_fmt       <= fmt;
                r_s1_opcode    <= opcode;
                r_s1_rd        <= rd;
                r_s1_rs1       <= rs1;
                r_s1_rs2       <= rs2;
                r_s1_funct3    <= funct3;
                r_s1_imm       <= imm;
                r_s1_range_err <= w_chk_range;
                r_s1_align_err <= w_chk_align;
                r_s1_fmt_err   <= w_chk_fmt;
            end
        end
    end

    // Assemble the RV32 word from the S1 fields; illegal formats become NOP.
    always_comb begin
        w_word = c_nop;
        case (fmt_e'(r_s1_fmt))
            FMT_I: w_word = {r_s1_imm[11:0], r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
            FMT_S: w_word = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                             r_s1_imm[4:0], r_s1_opcode};
            FMT_B: w_word = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1,
                             r_s1_funct3, r_s1_imm[4:1], r_s1_imm[11], r_s1_opcode};
            FMT_U: w_word = {r_s1_imm[31:12], r_s1_rd, r_s1_opcode};
            FMT_J: w_word = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11],
                             r_s1_imm[19:12], r_s1_rd, r_s1_opcode};
            default: w_word = c_nop;
        endcase
    end

    // S2: take the assembled word when empty or drained; hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid     <= 1'b0;
            r_s2_instr     <= 32'd0;
            r_s2_range_err <= 1'b0;
            r_s2_align_err <= 1'b0;
            r_s2_fmt_err   <= 1'b0;
        end else if (w_s2_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_instr     <= w_word;
                r_s2_range_err <= r_s1_range_err;
                r_s2_align_err <= r_s1_align_err;
                r_s2_fmt_err   <= r_s1_fmt_err;
            end
        end
    end

    // Count accepted requests carrying any error, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (w_in_fire && (w_chk_range || w_chk_align || w_chk_fmt)
                     && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign out_valid = r_s2_valid;
    assign instr     = r_s2_instr;
    assign range_err = r_s2_range_err;
    assign align_err = r_s2_align_err;
    assign fmt_err   = r_s2_fmt_err;
    assign err_count = r_err_count;

endmodule : instr_encoder
`default_nettype wire
